pe_sad_row: RTL and testbench
=============================

// Module: pe_sad_row
// PURPOSE
//  Parametrised successor of the single PE: LANES systolic PEs in one row, each computing
//  |crt - pre| per beat and accumulating ACC_LEN differences into a per-lane SAD.
//  Picks the minimum SAD and its lane index, and returns the result over a valid/ready port.
//  Sits between the block/search-window fetch and the motion-vector decision stage.
// PARAMETERS
//  PIXEL_W  8   pixel width, unsigned
//  LANES    4   PEs (candidate positions) per row, >=1
//  ACC_LEN  16  beats per SAD block; must be >=4
//  SAD_W    PIXEL_W+$clog2(ACC_LEN)   localparam, per-lane SAD width
//  IDX_W    max(1,$clog2(LANES))      localparam, lane index width
// PORTS
//  clk          in   1              clock, rising edge
//  rst          in   1              reset, asynchronous, active-low
//  flush        in   1              sync clear of block accumulation
//  in_valid     in   1              input beat valid
//  in_ready     out  1              input beat ready
//  crt_keep     in   1              1: hold current-block pixels; 0: load crt_pixel_i
//  crt_pixel_i  in   LANES*PIXEL_W  current-block pixel per lane, lane k at [k*PIXEL_W+:PIXEL_W]
//  pre_pixel_i  in   PIXEL_W        reference pixel, enters lane 0
//  crt_pixel_o  out  LANES*PIXEL_W  registered crt pixels (chain to next row)
//  pre_pixel_o  out  PIXEL_W        pre pixel leaving lane LANES-1 (chain)
//  ad           out  LANES*PIXEL_W  registered absolute difference per lane
//  ad_valid     out  1              ad holds a difference from an accepted beat
//  sad_valid    out  1              result valid
//  sad_ready    in   1              result consumed
//  sad_o        out  LANES*SAD_W    per-lane SAD
//  sad_min      out  SAD_W          minimum of sad_o
//  sad_idx      out  IDX_W          lane of sad_min; lowest index wins ties
// BEHAVIOUR
//  Reset: every register and output 0 (sad_valid=0, ad_valid=0); in_ready=1.
//  in_ready = !sad_valid || sad_ready (combinational). beat = in_valid && in_ready.
//  Stage A (on beat only): crt_reg[k] <= crt_keep ? crt_reg[k] : crt_pixel_i[k];
//   pre_reg[0] <= pre_pixel_i; pre_reg[k] <= pre_reg[k-1]. No beat: A holds.
//   a_valid <= beat. crt_pixel_o = crt_reg; pre_pixel_o = pre_reg[LANES-1].
//  Stage B: ad[k] <= |crt_reg[k]-pre_reg[k]| when a_valid (unsigned, no wrap);
//   ad_valid <= a_valid. ad holds its value when a_valid=0.
//  Stage C, when ad_valid: acc[k] += ad[k]; cnt++. When cnt==ACC_LEN-1:
//   sad_o[k] <= acc[k]+ad[k]; sad_min/sad_idx loaded from the same sums; acc<=0;
//   cnt<=0; sad_valid<=1. Accumulation never overflows SAD_W.
//  Latency: ACC_LEN-th beat at cycle t -> sad_valid=1 at t+3.
//  Stages B/C never stall; at most 2 beats are in flight when in_ready drops.
//   ACC_LEN>=4 guarantees no second completion while a result is held.
//  Output: sad_o/min/idx stable while sad_valid && !sad_ready.
//   Handshake clears sad_valid unless a completion occurs in the same cycle;
//   in that case the new result loads and sad_valid stays 1.
//  flush (sync, priority over accumulation): acc<=0, cnt<=0, a_valid<=0, ad_valid<=0.
//   crt_reg, pre_reg, ad and the held result are kept. A beat in the flush cycle is
//   discarded from the SAD but still updates stage A.
//  rst low at any time: immediate clear, in-flight block lost.
// TESTING (LANES=4, PIXEL_W=8, ACC_LEN=16, sad_ready=1 unless stated)
//  1 rst low mid-block -> all outputs 0 at once, in_ready=1; after release 16 beats
//    give a correct fresh SAD.
//  2 crt=0, keep=0, pre=255 for 16 beats -> every lane 4080 except lane k sees k reset-zeros:
//    sad_o={3315,3570,3825,4080} (lane3..0), sad_min=3315, idx=3, valid 3 cycles after beat 16.
//  3 crt=0, pre=1,2..16 -> sad_o lane0..3 = 136,120,105,91; sad_min=91, idx=3.
//  4 crt_keep=1 after beat1 with crt={9,9,9,9} then crt_pixel_i=0, pre=9 -> lane0 SAD 0;
//    keep=0 -> SAD reflects new crt.
//  5 sad_ready=0 at completion -> in_ready=0, beats ignored, pre chain frozen, sad_o stable;
//    release -> next block result exact; same-cycle handshake+completion keeps valid=1.
//  6 flush after 5 beats, pre=255 crt=0 steady state, then 16 beats -> all lanes 4080.

Source files
------------

// File: rtl/pe_sad_row.sv
// One row of LANES systolic absolute-difference PEs. Each lane accumulates ACC_LEN
// differences into a SAD; the row reports all SADs plus the minimum and its lane.
module pe_sad_row #(
   parameter int PIXEL_W = 8,
   parameter int LANES   = 4,
   parameter int ACC_LEN = 16,
   localparam int SAD_W  = PIXEL_W + $clog2(ACC_LEN),
   localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic                     crt_keep,
   input  logic [LANES*PIXEL_W-1:0] crt_pixel_i,
   input  logic [PIXEL_W-1:0]       pre_pixel_i,
   output logic [LANES*PIXEL_W-1:0] crt_pixel_o,
   output logic [PIXEL_W-1:0]       pre_pixel_o,
   output logic [LANES*PIXEL_W-1:0] ad,
   output logic                     ad_valid,
   output logic                     sad_valid,
   input  logic                     sad_ready,
   output logic [LANES*SAD_W-1:0]   sad_o,
   output logic [SAD_W-1:0]         sad_min,
   output logic [IDX_W-1:0]         sad_idx
);

   localparam int CNT_W = $clog2(ACC_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);

   // Handshake: a beat moves when in_valid && in_ready; a result is consumed when
   // sad_valid && sad_ready. Only stage A stalls; stages B and C always advance.
   logic                 beat;
   logic [PIXEL_W-1:0]   crt_q  [LANES];
   logic [PIXEL_W-1:0]   pre_q  [LANES];
   logic                 a_valid_q;
   logic [PIXEL_W-1:0]   ad_q   [LANES];
   logic [PIXEL_W-1:0]   ad_d   [LANES];
   logic                 ad_valid_q;
   logic [SAD_W-1:0]     acc_q  [LANES];
   logic [SAD_W-1:0]     sum_d  [LANES];
   logic [SAD_W-1:0]     sad_q  [LANES];
   logic [CNT_W-1:0]     cnt_q;
   logic [SAD_W-1:0]     min_q, min_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic                 sad_valid_q, sad_valid_d;
   logic                 complete_d;

   assign in_ready = !sad_valid_q || sad_ready;
   assign beat     = in_valid && in_ready;

   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         ad_d[k]  = (crt_q[k] >= pre_q[k]) ? (crt_q[k] - pre_q[k]) : (pre_q[k] - crt_q[k]);
         sum_d[k] = acc_q[k] + {{(SAD_W-PIXEL_W){1'b0}}, ad_q[k]};
      end
   end

   // Strict less-than keeps the lowest lane on ties.
   always_comb begin
      min_d = sum_d[0];
      idx_d = '0;
      for (int k = 1; k < LANES; k++) begin
         if (sum_d[k] < min_d) begin
            min_d = sum_d[k];
            idx_d = IDX_W'(k);
         end
      end
   end

   assign complete_d  = ad_valid_q && !flush && (cnt_q == CNT_LAST);
   assign sad_valid_d = complete_d ? 1'b1 : (sad_ready ? 1'b0 : sad_valid_q);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < LANES; k++) begin
            crt_q[k] <= '0;
            pre_q[k] <= '0;
         end
         a_valid_q <= 1'b0;
      end else begin
         a_valid_q <= beat && !flush;
         if (beat) begin
            for (int k = 0; k < LANES; k++) begin
               if (!crt_keep) crt_q[k] <= crt_pixel_i[k*PIXEL_W +: PIXEL_W];
            end
            pre_q[0] <= pre_pixel_i;
            for (int k = 1; k < LANES; k++) pre_q[k] <= pre_q[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < LANES; k++) ad_q[k] <= '0;
         ad_valid_q <= 1'b0;
      end else begin
         ad_valid_q <= a_valid_q && !flush;
         if (a_valid_q && !flush) begin
            for (int k = 0; k < LANES; k++) ad_q[k] <= ad_d[k];
         end
      end
   end

   // Flush drops the partial block but leaves any held result untouched.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < LANES; k++) begin
            acc_q[k] <= '0;
            sad_q[k] <= '0;
         end
         cnt_q       <= '0;
         min_q       <= '0;
         idx_q       <= '0;
         sad_valid_q <= 1'b0;
      end else begin
         sad_valid_q <= sad_valid_d;
         if (flush) begin
            for (int k = 0; k < LANES; k++) acc_q[k] <= '0;
            cnt_q <= '0;
         end else if (ad_valid_q) begin
            if (complete_d) begin
               for (int k = 0; k < LANES; k++) begin
                  sad_q[k] <= sum_d[k];
                  acc_q[k] <= '0;
               end
               min_q <= min_d;
               idx_q <= idx_d;
               cnt_q <= '0;
            end else begin
               for (int k = 0; k < LANES; k++) acc_q[k] <= sum_d[k];
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end
   end

   for (genvar k = 0; k < LANES; k++) begin : g_out
      assign crt_pixel_o[k*PIXEL_W +: PIXEL_W] = crt_q[k];
      assign ad[k*PIXEL_W +: PIXEL_W]          = ad_q[k];
      assign sad_o[k*SAD_W +: SAD_W]           = sad_q[k];
   end

   assign pre_pixel_o = pre_q[LANES-1];
   assign ad_valid    = ad_valid_q;
   assign sad_valid   = sad_valid_q;
   assign sad_min     = min_q;
   assign sad_idx     = idx_q;

endmodule

// File: tb/tb_pe_sad_row.sv
// Directed bench for pe_sad_row: a beat-level reference model fills an expected
// queue when beats are accepted; results are popped and compared on handshake.
module tb_pe_sad_row;

   localparam int PW  = 8;
   localparam int NL  = 4;
   localparam int AL  = 16;
   localparam int SW  = 12;
   localparam int IW  = 2;
   localparam int EW  = NL*SW + SW + IW;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            flush = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic            crt_keep = 1'b0;
   logic [NL*PW-1:0] crt_pixel_i = '0;
   logic [PW-1:0]   pre_pixel_i = '0;
   logic [NL*PW-1:0] crt_pixel_o;
   logic [PW-1:0]   pre_pixel_o;
   logic [NL*PW-1:0] ad;
   logic            ad_valid;
   logic            sad_valid;
   logic            sad_ready = 1'b1;
   logic [NL*SW-1:0] sad_o;
   logic [SW-1:0]   sad_min;
   logic [IW-1:0]   sad_idx;

   int n_checks = 0;
   int n_fail   = 0;

   logic [EW-1:0] exp_q[$];
   logic [PW-1:0] crt_m [NL];
   logic [PW-1:0] pre_m [NL];
   int unsigned   acc_m [NL];
   int            cnt_m;

   pe_sad_row #(.PIXEL_W(PW), .LANES(NL), .ACC_LEN(AL)) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .crt_keep(crt_keep), .crt_pixel_i(crt_pixel_i), .pre_pixel_i(pre_pixel_i),
      .crt_pixel_o(crt_pixel_o), .pre_pixel_o(pre_pixel_o), .ad(ad), .ad_valid(ad_valid),
      .sad_valid(sad_valid), .sad_ready(sad_ready), .sad_o(sad_o), .sad_min(sad_min),
      .sad_idx(sad_idx)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model and result monitor, both sampled mid-cycle.
   always @(negedge clk) begin
      logic [EW-1:0]  e;
      logic [SW-1:0]  mn;
      logic [IW-1:0]  mi;
      int unsigned    d;
      if (!rst) begin
         for (int k = 0; k < NL; k++) begin
            crt_m[k] = '0; pre_m[k] = '0; acc_m[k] = 0;
         end
         cnt_m = 0;
         exp_q.delete();
      end else begin
         if (sad_valid && sad_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_result", 64'(sad_valid), 64'd0);
            end else begin
               e = exp_q.pop_front();
               check("result", 64'({sad_o, sad_min, sad_idx}), 64'(e));
            end
         end
         if (flush) begin
            for (int k = 0; k < NL; k++) acc_m[k] = 0;
            cnt_m = 0;
         end
         if (in_valid && in_ready) begin
            if (!crt_keep)
               for (int k = 0; k < NL; k++) crt_m[k] = crt_pixel_i[k*PW +: PW];
            for (int k = NL-1; k > 0; k--) pre_m[k] = pre_m[k-1];
            pre_m[0] = pre_pixel_i;
            if (!flush) begin
               for (int k = 0; k < NL; k++) begin
                  d = (crt_m[k] >= pre_m[k]) ? 32'(crt_m[k] - pre_m[k]) : 32'(pre_m[k] - crt_m[k]);
                  acc_m[k] += d;
               end
               cnt_m++;
               if (cnt_m == AL) begin
                  mn = SW'(acc_m[0]);
                  mi = '0;
                  for (int k = 1; k < NL; k++)
                     if (acc_m[k] < 32'(mn)) begin mn = SW'(acc_m[k]); mi = IW'(k); end
                  e = '0;
                  for (int k = 0; k < NL; k++) e[SW+IW+k*SW +: SW] = SW'(acc_m[k]);
                  e[IW +: SW] = mn;
                  e[IW-1:0]   = mi;
                  exp_q.push_back(e);
                  for (int k = 0; k < NL; k++) acc_m[k] = 0;
                  cnt_m = 0;
               end
            end
         end
      end
   end

   task automatic drive(input logic [NL*PW-1:0] crt, input logic [PW-1:0] pre, input logic keep);
      crt_pixel_i = crt;
      pre_pixel_i = pre;
      crt_keep    = keep;
      in_valid    = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic drive_rand();
      logic [NL*PW-1:0] c;
      for (int k = 0; k < NL; k++) c[k*PW +: PW] = PW'($urandom_range(0, 255));
      drive(c, PW'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      flush    = 1'b0;
      rst      = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
   endtask

   // Called right after the final beat of a block has been taken.
   task automatic check_latency(input string tag);
      in_valid = 1'b0;
      check({tag, "_lat1"}, 64'(sad_valid), 64'd0);
      @(posedge clk); #1;
      check({tag, "_lat2"}, 64'(sad_valid), 64'd0);
      @(posedge clk); #1;
      check({tag, "_lat3"}, 64'(sad_valid), 64'd1);
   endtask

   initial begin
      logic [NL*PW-1:0] crt_pk;
      logic [EW-1:0]    head;

      // 1: reset state, then reset mid-block
      repeat (2) begin @(posedge clk); #1; end
      check("reset_outputs", 64'({crt_pixel_o, pre_pixel_o, ad, ad_valid, sad_valid}), 64'd0);
      check("reset_sad", 64'({sad_o, sad_min, sad_idx}), 64'd0);
      check("reset_in_ready", 64'(in_ready), 64'd1);
      rst = 1'b1;
      for (int i = 0; i < AL; i++) drive({4{8'd200}}, PW'(i * 3), 1'b0);
      idle(5);
      for (int i = 0; i < 8; i++) drive_rand();
      rst = 1'b0;
      #1;
      check("midreset_outputs", 64'({crt_pixel_o, pre_pixel_o, ad, ad_valid, sad_valid}), 64'd0);
      check("midreset_sad", 64'({sad_o, sad_min, sad_idx}), 64'd0);
      check("midreset_in_ready", 64'(in_ready), 64'd1);
      do_reset();
      for (int i = 0; i < AL; i++) drive_rand();
      idle(5);

      // 2: constant pre=255 from a reset pipeline
      do_reset();
      for (int i = 0; i < AL; i++) begin
         drive('0, 8'd255, 1'b0);
         if (i == 1) begin
            check("ad_first", 64'(ad), 64'h0000_00FF);
            check("ad_valid_first", 64'(ad_valid), 64'd1);
         end
      end
      check_latency("t2");
      check("t2_sad_o", 64'(sad_o), 64'({12'd3315, 12'd3570, 12'd3825, 12'd4080}));
      check("t2_min", 64'(sad_min), 64'd3315);
      check("t2_idx", 64'(sad_idx), 64'd3);
      idle(3);

      // 3: ramp pre=1..16
      do_reset();
      for (int i = 0; i < AL; i++) drive('0, PW'(i + 1), 1'b0);
      check_latency("t3");
      check("t3_sad_o", 64'(sad_o), 64'({12'd91, 12'd105, 12'd120, 12'd136}));
      check("t3_min", 64'(sad_min), 64'd91);
      check("t3_idx", 64'(sad_idx), 64'd3);
      idle(3);

      // 4: crt_keep holds the current block
      drive({4{8'd9}}, 8'd9, 1'b0);
      for (int i = 1; i < AL; i++) drive('0, 8'd9, 1'b1);
      check_latency("t4");
      check("t4_lane0_zero", 64'(sad_o[SW-1:0]), 64'd0);
      idle(3);
      for (int i = 0; i < AL; i++) drive({8'd40, 8'd30, 8'd20, 8'd10}, PW'($urandom_range(0, 255)), 1'b0);
      idle(5);

      // 5: back-pressure on the result port
      sad_ready = 1'b0;
      for (int i = 0; i < AL; i++) drive_rand();
      for (int i = 0; i < 4; i++) drive_rand();
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_valid", 64'(sad_valid), 64'd1);
      head = exp_q[0];
      check("stall_sad_hold", 64'({sad_o, sad_min, sad_idx}), 64'(head));
      for (int i = 0; i < 3; i++) drive_rand();
      for (int k = 0; k < NL; k++) crt_pk[k*PW +: PW] = crt_m[k];
      check("stall_pre_frozen", 64'(pre_pixel_o), 64'(pre_m[NL-1]));
      check("stall_crt_frozen", 64'(crt_pixel_o), 64'(crt_pk));
      check("stall_sad_hold2", 64'({sad_o, sad_min, sad_idx}), 64'(head));
      sad_ready = 1'b1;
      for (int i = 0; i < AL - 2; i++) drive_rand();
      idle(5);
      for (int i = 0; i < 2*AL; i++) drive_rand();
      idle(5);

      // 6: flush mid-block, then a full steady-state block
      for (int i = 0; i < 5; i++) drive('0, 8'd255, 1'b0);
      flush = 1'b1;
      drive('0, 8'd255, 1'b0);
      flush = 1'b0;
      for (int i = 0; i < AL; i++) drive('0, 8'd255, 1'b0);
      check_latency("t6");
      check("t6_sad_o", 64'(sad_o), 64'({4{12'd4080}}));
      check("t6_min", 64'(sad_min), 64'd4080);
      check("t6_idx", 64'(sad_idx), 64'd0);
      idle(3);

      for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin @(posedge clk); #1; end
      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
